// File: rtl/qspinor_seq.sv
// rtl/qspinor_seq.sv - QSPI NOR transaction sequencer driving a per-byte shifter
module qspinor_seq #(
    parameter int CS_SETUP    = 1,
    parameter int CS_HIGH_MIN = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req,
    input  logic [7:0]  req_cmd,
    input  logic        req_has_addr,
    input  logic [23:0] req_addr,
    input  logic [2:0]  req_dummy,
    input  logic [2:0]  req_len,
    input  logic        req_we,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  cfg_cmd_wid,
    input  logic [1:0]  cfg_addr_wid,
    input  logic [1:0]  cfg_data_wid,
    output logic        ack,
    output logic [31:0] rdata,
    output logic        busy,
    output logic        spi_cs_n,
    output logic        io_trig,
    input  logic        io_done,
    output logic [7:0]  io_dout,
    input  logic [7:0]  io_din,
    output logic        io_dir,
    output logic [1:0]  io_wid
);

    typedef enum logic [2:0] {
        IDLE,
        CSSET,
        CMD,
        ADDR,
        DUMMY,
        DATA,
        CSHOLD
    } state_t;

    // Timer terminal counts; a zero-cycle setting still spends one cycle in the wait state.
    localparam logic [7:0] SETUP_LAST = 8'((CS_SETUP > 1) ? (CS_SETUP - 1) : 0);
    localparam logic [7:0] HOLD_LAST  = 8'((CS_HIGH_MIN > 1) ? (CS_HIGH_MIN - 1) : 0);

    state_t      state, state_nx;
    logic [2:0]  cnt, cnt_nx;
    logic [7:0]  timer, timer_nx;
    logic        waiting, waiting_nx;

    logic        ack_nx, busy_nx, cs_n_nx, trig_nx, dir_nx;
    logic [7:0]  dout_nx;
    logic [1:0]  wid_nx;
    logic [31:0] rdata_nx;

    logic [7:0]  lat_cmd;
    logic        lat_has_addr;
    logic [23:0] lat_addr;
    logic [2:0]  lat_dummy;
    logic [2:0]  lat_len;
    logic        lat_we;
    logic [31:0] lat_wdata;
    logic [1:0]  lat_cmd_wid, lat_addr_wid, lat_data_wid;

    logic        accept;
    logic [2:0]  cur_len;
    logic        issue;
    state_t      tgt_state;
    logic [2:0]  tgt_idx;

    // A request held across ack is not re-accepted in the ack cycle itself.
    assign accept = (state == IDLE) && req && !ack;

    // First non-empty phase following phase p; CSHOLD when nothing is left to send.
    function automatic state_t next_after(input state_t p, input logic has_addr,
                                          input logic [2:0] dummy, input logic [2:0] len);
        state_t r;
        r = CSHOLD;
        case (p)
            CSSET:   r = CMD;
            CMD:     r = has_addr ? ADDR : (dummy != 3'd0) ? DUMMY : (len != 3'd0) ? DATA : CSHOLD;
            ADDR:    r = (dummy != 3'd0) ? DUMMY : (len != 3'd0) ? DATA : CSHOLD;
            DUMMY:   r = (len != 3'd0) ? DATA : CSHOLD;
            default: r = CSHOLD;
        endcase
        return r;
    endfunction

    // Capture the whole transaction at acceptance so the bus side may change afterwards.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            lat_cmd      <= 8'd0;
            lat_has_addr <= 1'b0;
            lat_addr     <= 24'd0;
            lat_dummy    <= 3'd0;
            lat_len      <= 3'd0;
            lat_we       <= 1'b0;
            lat_wdata    <= 32'd0;
            lat_cmd_wid  <= 2'd0;
            lat_addr_wid <= 2'd0;
            lat_data_wid <= 2'd0;
        end else if (accept) begin
            lat_cmd      <= req_cmd;
            lat_has_addr <= req_has_addr;
            lat_addr     <= req_addr;
            lat_dummy    <= req_dummy;
            lat_len      <= (req_len > 3'd4) ? 3'd4 : req_len;
            lat_we       <= req_we;
            lat_wdata    <= req_wdata;
            lat_cmd_wid  <= cfg_cmd_wid;
            lat_addr_wid <= cfg_addr_wid;
            lat_data_wid <= cfg_data_wid;
        end
    end

    // Byte count of the phase currently being shifted.
    always_comb begin
        cur_len = 3'd1;
        case (state)
            CMD:     cur_len = 3'd1;
            ADDR:    cur_len = 3'd3;
            DUMMY:   cur_len = lat_dummy;
            DATA:    cur_len = lat_len;
            default: cur_len = 3'd1;
        endcase
    end

    // Next-state and next-output logic; every shifter byte is launched through 'issue'.
    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        timer_nx   = timer;
        waiting_nx = waiting;
        ack_nx     = 1'b0;
        busy_nx    = busy;
        cs_n_nx    = spi_cs_n;
        trig_nx    = 1'b0;
        dout_nx    = io_dout;
        dir_nx     = io_dir;
        wid_nx     = io_wid;
        rdata_nx   = rdata;
        issue      = 1'b0;
        tgt_state  = state;
        tgt_idx    = 3'd0;

        case (state)
            IDLE: begin
                if (accept) begin
                    state_nx = CSSET;
                    timer_nx = 8'd0;
                    busy_nx  = 1'b1;
                    cs_n_nx  = 1'b0;
                    rdata_nx = 32'd0;
                end
            end
            CSSET: begin
                if (timer >= SETUP_LAST) begin
                    issue     = 1'b1;
                    tgt_state = CMD;
                    tgt_idx   = 3'd0;
                end else begin
                    timer_nx = timer + 8'd1;
                end
            end
            CMD, ADDR, DUMMY, DATA: begin
                // io_done outside an outstanding byte is ignored via 'waiting'.
                if (waiting && io_done) begin
                    waiting_nx = 1'b0;
                    if (state == DATA && !lat_we) begin
                        rdata_nx[{cnt[1:0], 3'b000} +: 8] = io_din;
                    end
                    if (cnt == 3'(cur_len - 3'd1)) begin
                        tgt_state = next_after(state, lat_has_addr, lat_dummy, lat_len);
                        tgt_idx   = 3'd0;
                        if (tgt_state == CSHOLD) begin
                            state_nx = CSHOLD;
                            cs_n_nx  = 1'b1;
                            timer_nx = 8'd0;
                        end else begin
                            issue = 1'b1;
                        end
                    end else begin
                        tgt_state = state;
                        tgt_idx   = 3'(cnt + 3'd1);
                        issue     = 1'b1;
                    end
                end
            end
            CSHOLD: begin
                if (timer >= HOLD_LAST) begin
                    ack_nx   = 1'b1;
                    busy_nx  = 1'b0;
                    state_nx = IDLE;
                end else begin
                    timer_nx = timer + 8'd1;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        if (issue) begin
            state_nx   = tgt_state;
            cnt_nx     = tgt_idx;
            trig_nx    = 1'b1;
            waiting_nx = 1'b1;
            case (tgt_state)
                CMD: begin
                    dout_nx = lat_cmd;
                    dir_nx  = 1'b1;
                    wid_nx  = lat_cmd_wid;
                end
                ADDR: begin
                    case (tgt_idx)
                        3'd0:    dout_nx = lat_addr[23:16];
                        3'd1:    dout_nx = lat_addr[15:8];
                        default: dout_nx = lat_addr[7:0];
                    endcase
                    dir_nx = 1'b1;
                    wid_nx = lat_addr_wid;
                end
                DUMMY: begin
                    dout_nx = 8'hFF;
                    dir_nx  = 1'b0;
                    wid_nx  = lat_addr_wid;
                end
                default: begin
                    dout_nx = lat_we ? lat_wdata[{tgt_idx[1:0], 3'b000} +: 8] : 8'h00;
                    dir_nx  = lat_we;
                    wid_nx  = lat_data_wid;
                end
            endcase
        end
    end

    // State and registered outputs; reset clears everything and suppresses any pending ack.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state    <= IDLE;
            cnt      <= 3'd0;
            timer    <= 8'd0;
            waiting  <= 1'b0;
            ack      <= 1'b0;
            busy     <= 1'b0;
            spi_cs_n <= 1'b1;
            io_trig  <= 1'b0;
            io_dout  <= 8'd0;
            io_dir   <= 1'b0;
            io_wid   <= 2'd0;
            rdata    <= 32'd0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            timer    <= timer_nx;
            waiting  <= waiting_nx;
            ack      <= ack_nx;
            busy     <= busy_nx;
            spi_cs_n <= cs_n_nx;
            io_trig  <= trig_nx;
            io_dout  <= dout_nx;
            io_dir   <= dir_nx;
            io_wid   <= wid_nx;
            rdata    <= rdata_nx;
        end
    end

endmodule

// File: tb/tb_qspinor_seq.sv
// tb/tb_qspinor_seq.sv - randomized self-checking bench for qspinor_seq with shifter model
module tb_qspinor_seq;
    localparam int CS_SETUP    = 1;
    localparam int CS_HIGH_MIN = 2;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        req = 1'b0;
    logic [7:0]  req_cmd = 8'd0;
    logic        req_has_addr = 1'b0;
    logic [23:0] req_addr = 24'd0;
    logic [2:0]  req_dummy = 3'd0;
    logic [2:0]  req_len = 3'd0;
    logic        req_we = 1'b0;
    logic [31:0] req_wdata = 32'd0;
    logic [1:0]  cfg_cmd_wid = 2'd0;
    logic [1:0]  cfg_addr_wid = 2'd0;
    logic [1:0]  cfg_data_wid = 2'd0;
    logic        ack;
    logic [31:0] rdata;
    logic        busy;
    logic        spi_cs_n;
    logic        io_trig;
    logic        io_done;
    logic [7:0]  io_dout;
    logic [7:0]  io_din;
    logic        io_dir;
    logic [1:0]  io_wid;

    always #5 clk = ~clk;

    qspinor_seq #(.CS_SETUP(CS_SETUP), .CS_HIGH_MIN(CS_HIGH_MIN)) dut (
        .clk(clk), .rstn(rstn), .req(req), .req_cmd(req_cmd), .req_has_addr(req_has_addr),
        .req_addr(req_addr), .req_dummy(req_dummy), .req_len(req_len), .req_we(req_we),
        .req_wdata(req_wdata), .cfg_cmd_wid(cfg_cmd_wid), .cfg_addr_wid(cfg_addr_wid),
        .cfg_data_wid(cfg_data_wid), .ack(ack), .rdata(rdata), .busy(busy), .spi_cs_n(spi_cs_n),
        .io_trig(io_trig), .io_done(io_done), .io_dout(io_dout), .io_din(io_din),
        .io_dir(io_dir), .io_wid(io_wid)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected byte stream of the current transaction.
    logic [7:0] exp_dout [0:31];
    logic       exp_dir  [0:31];
    logic [1:0] exp_wid  [0:31];
    logic       exp_care [0:31];
    int         exp_n = 0;

    // Shifter model state and logs.
    logic [7:0] din_log   [0:31];
    logic [7:0] dout_log  [0:31];
    logic       dir_log   [0:31];
    logic [7:0] force_din [0:31];
    logic       force_en  [0:31];
    int         sh_cnt = 0;
    int         sh_cur = 0;
    int         sh_cd = 0;
    bit         sh_new = 1'b1;
    bit         spurious = 1'b0;

    // Shifter: answers each io_trig with io_done after a random 1..4 cycles.
    initial begin
        io_done = 1'b0;
        io_din  = 8'd0;
        for (int i = 0; i < 32; i++) force_en[i] = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            io_done = 1'b0;
            if (!rstn) begin
                sh_cd  = 0;
                sh_new = 1'b1;
            end else begin
                if (spi_cs_n) sh_new = 1'b1;
                if (io_trig) begin
                    if (sh_new) begin
                        sh_cnt = 0;
                        sh_new = 1'b0;
                    end
                    sh_cur = sh_cnt;
                    dout_log[sh_cur] = io_dout;
                    dir_log[sh_cur]  = io_dir;
                    sh_cnt++;
                    sh_cd = $urandom_range(1, 4);
                end else if (sh_cd > 0) begin
                    sh_cd--;
                    if (sh_cd == 0) begin
                        io_din = force_en[sh_cur] ? force_din[sh_cur] : 8'($urandom);
                        din_log[sh_cur] = io_din;
                        io_done = 1'b1;
                    end
                end else if (spurious) begin
                    io_din  = 8'hA5;
                    io_done = 1'b1;
                end
            end
        end
    end

    // Per-cycle protocol checker against the expected byte stream and timing rules.
    int   cyc = 0;
    int   last_done = -100;
    int   cs_rise = -100;
    int   cs_high_run = 0;
    int   cs_low_run = 0;
    int   mon_idx = 0;
    bit   outstanding = 1'b0;
    bit   mon_new = 1'b1;
    bit   prev_cs = 1'b1;
    bit   prev_ack = 1'b0;
    bit   prev_rstn = 1'b1;
    logic [7:0] sv_dout;
    logic       sv_dir;
    logic [1:0] sv_wid;

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (!rstn) begin
                if (!prev_rstn) begin
                    check("rst_cs_n", spi_cs_n, 1);
                    check("rst_busy", busy, 0);
                    check("rst_ack", ack, 0);
                    check("rst_trig", io_trig, 0);
                    check("rst_dout", io_dout, 0);
                    check("rst_dir", io_dir, 0);
                    check("rst_wid", io_wid, 0);
                    check("rst_rdata", rdata, 0);
                end
                outstanding = 1'b0;
                mon_new     = 1'b1;
                prev_cs     = 1'b1;
                prev_ack    = 1'b0;
                cs_high_run = 0;
            end else begin
                if (io_trig) begin
                    check("trig_cs_low", spi_cs_n, 0);
                    if (mon_new) begin
                        mon_idx = 0;
                        mon_new = 1'b0;
                        check("cs_setup", cs_low_run, CS_SETUP);
                    end else begin
                        check("trig_gap", cyc, last_done + 1);
                    end
                    if (mon_idx < exp_n) begin
                        if (exp_care[mon_idx]) check("byte_dout", io_dout, exp_dout[mon_idx]);
                        check("byte_dir", io_dir, exp_dir[mon_idx]);
                        check("byte_wid", io_wid, exp_wid[mon_idx]);
                    end else begin
                        check("extra_trig", mon_idx, exp_n);
                    end
                    mon_idx++;
                    outstanding = 1'b1;
                    sv_dout = io_dout;
                    sv_dir  = io_dir;
                    sv_wid  = io_wid;
                end else if (outstanding) begin
                    check("hold_dout", io_dout, sv_dout);
                    check("hold_dir", io_dir, sv_dir);
                    check("hold_wid", io_wid, sv_wid);
                end
                if (io_done && outstanding && !io_trig) begin
                    outstanding = 1'b0;
                    last_done = cyc;
                end
                if (!spi_cs_n) begin
                    if (prev_cs) begin
                        check("cs_high_min", cs_high_run >= CS_HIGH_MIN, 1);
                        cs_low_run = 0;
                    end
                    check("busy_while_cs", busy, 1);
                    cs_low_run++;
                end else begin
                    if (!prev_cs) begin
                        cs_high_run = 0;
                        cs_rise = cyc;
                        mon_new = 1'b1;
                        check("cs_rise", cyc, last_done + 1);
                    end
                    cs_high_run++;
                end
                if (ack) begin
                    check("ack_pulse", prev_ack, 0);
                    check("ack_delay", cyc, cs_rise + CS_HIGH_MIN);
                    check("ack_bytes", mon_idx, exp_n);
                    check("ack_cs_high", spi_cs_n, 1);
                end
                prev_cs  = spi_cs_n;
                prev_ack = ack;
            end
            prev_rstn = rstn;
        end
    end

    // Builds the expected byte stream from the transaction fields.
    task automatic build_model(input logic [7:0] cmd, input logic has_addr, input logic [23:0] addr,
                               input logic [2:0] dummy, input int eff, input logic we,
                               input logic [31:0] wdata, input logic [1:0] cw, input logic [1:0] aw,
                               input logic [1:0] dw);
        int n;
        n = 0;
        exp_dout[n] = cmd; exp_dir[n] = 1'b1; exp_wid[n] = cw; exp_care[n] = 1'b1; n++;
        if (has_addr) begin
            for (int b = 2; b >= 0; b--) begin
                exp_dout[n] = 8'(addr >> (8 * b)); exp_dir[n] = 1'b1; exp_wid[n] = aw;
                exp_care[n] = 1'b1; n++;
            end
        end
        for (int d = 0; d < int'(dummy); d++) begin
            exp_dout[n] = 8'hFF; exp_dir[n] = 1'b0; exp_wid[n] = aw; exp_care[n] = 1'b1; n++;
        end
        for (int k = 0; k < eff; k++) begin
            exp_dout[n] = 8'(wdata >> (8 * k)); exp_dir[n] = we; exp_wid[n] = dw;
            exp_care[n] = we; n++;
        end
        exp_n = n;
    endtask

    task automatic run_txn(input logic [7:0] cmd, input logic has_addr, input logic [23:0] addr,
                           input logic [2:0] dummy, input logic [2:0] len, input logic we,
                           input logic [31:0] wdata, input logic [1:0] cw, input logic [1:0] aw,
                           input logic [1:0] dw, input bit hold);
        int eff;
        bit got;
        logic [31:0] exp_rd;
        eff = (len > 3'd4) ? 4 : int'(len);
        build_model(cmd, has_addr, addr, dummy, eff, we, wdata, cw, aw, dw);
        req_cmd = cmd; req_has_addr = has_addr; req_addr = addr; req_dummy = dummy;
        req_len = len; req_we = we; req_wdata = wdata;
        cfg_cmd_wid = cw; cfg_addr_wid = aw; cfg_data_wid = dw;
        req = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clk);
            if (ack) got = 1'b1;
        end
        check("ack_timeout", got, 1);
        if (got) begin
            exp_rd = 32'd0;
            if (!we) begin
                for (int k = 0; k < eff; k++) exp_rd[8 * k +: 8] = din_log[sh_cnt - eff + k];
            end
            check("rdata", rdata, exp_rd);
            check("byte_count", sh_cnt, exp_n);
        end
        @(posedge clk);
        #1;
        if (!hold) req = 1'b0;
    endtask

    task automatic clear_force();
        for (int i = 0; i < 32; i++) force_en[i] = 1'b0;
    endtask

    logic [7:0] quad_seq [0:6];
    bit seen;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Spurious io_done while idle must not start anything.
        spurious = 1'b1;
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (io_trig || !spi_cs_n || busy) seen = 1'b1;
        end
        check("idle_spurious", seen, 0);
        spurious = 1'b0;
        @(posedge clk);
        #1;

        // Read status.
        clear_force();
        force_en[1] = 1'b1; force_din[1] = 8'h5A;
        run_txn(8'h05, 1'b0, 24'd0, 3'd0, 3'd1, 1'b0, 32'd0, 2'd0, 2'd0, 2'd0, 1'b0);
        check("rs_rdata_lit", rdata, 32'h0000005A);
        check("rs_trigs_lit", sh_cnt, 2);
        check("rs_dir0_lit", dir_log[0], 1);
        check("rs_dir1_lit", dir_log[1], 0);

        // Quad I/O read.
        clear_force();
        force_en[7] = 1'b1; force_din[7] = 8'h11;
        force_en[8] = 1'b1; force_din[8] = 8'h22;
        force_en[9] = 1'b1; force_din[9] = 8'h33;
        force_en[10] = 1'b1; force_din[10] = 8'h44;
        run_txn(8'hEB, 1'b1, 24'h123456, 3'd3, 3'd4, 1'b0, 32'd0, 2'd0, 2'd2, 2'd2, 1'b0);
        quad_seq[0] = 8'hEB; quad_seq[1] = 8'h12; quad_seq[2] = 8'h34; quad_seq[3] = 8'h56;
        quad_seq[4] = 8'hFF; quad_seq[5] = 8'hFF; quad_seq[6] = 8'hFF;
        for (int i = 0; i < 7; i++) check("quad_dout_lit", dout_log[i], quad_seq[i]);
        check("quad_rdata_lit", rdata, 32'h44332211);

        // Write enable: command byte only.
        clear_force();
        run_txn(8'h06, 1'b0, 24'd0, 3'd0, 3'd0, 1'b0, 32'd0, 2'd0, 2'd0, 2'd0, 1'b0);
        check("wren_trigs_lit", sh_cnt, 1);

        // Page program.
        run_txn(8'h32, 1'b1, 24'h000100, 3'd0, 3'd2, 1'b1, 32'h0000BEEF, 2'd0, 2'd0, 2'd2, 1'b0);
        check("pp_d0_lit", dout_log[4], 8'hEF);
        check("pp_d1_lit", dout_log[5], 8'hBE);
        for (int i = 0; i < 6; i++) check("pp_dir_lit", dir_log[i], 1);

        // Reset in the ADDR phase.
        clear_force();
        build_model(8'h0B, 1'b1, 24'hABCDEF, 3'd1, 4, 1'b0, 32'd0, 2'd0, 2'd0, 2'd0);
        req_cmd = 8'h0B; req_has_addr = 1'b1; req_addr = 24'hABCDEF; req_dummy = 3'd1;
        req_len = 3'd4; req_we = 1'b0; req_wdata = 32'd0;
        cfg_cmd_wid = 2'd0; cfg_addr_wid = 2'd0; cfg_data_wid = 2'd0;
        req = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (!sh_new && sh_cnt == 2) seen = 1'b1;
        end
        check("rst_reach_addr", seen, 1);
        @(posedge clk);
        #1;
        rstn = 1'b0;
        req = 1'b0;
        @(posedge clk);
        #1;
        check("rst_mid_cs_n", spi_cs_n, 1);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_ack", ack, 0);
        check("rst_mid_trig", io_trig, 0);
        rstn = 1'b1;
        exp_n = 0;
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (ack) seen = 1'b1;
        end
        check("rst_no_ack", seen, 0);
        @(posedge clk);
        #1;
        run_txn(8'h03, 1'b1, 24'h00ABCD, 3'd0, 3'd3, 1'b0, 32'd0, 2'd1, 2'd1, 2'd1, 1'b0);

        // req held across ack: back-to-back transactions.
        run_txn(8'h9F, 1'b0, 24'd0, 3'd0, 3'd3, 1'b0, 32'd0, 2'd0, 2'd0, 2'd0, 1'b1);
        run_txn(8'h02, 1'b1, 24'h00F000, 3'd0, 3'd4, 1'b1, 32'hCAFEF00D, 2'd0, 2'd0, 2'd0, 1'b1);
        run_txn(8'h05, 1'b0, 24'd0, 3'd0, 3'd1, 1'b0, 32'd0, 2'd0, 2'd0, 2'd0, 1'b0);

        // Randomized transactions, some back-to-back, some with stray io_done pulses.
        for (int t = 0; t < 30; t++) begin
            clear_force();
            spurious = ($urandom_range(0, 3) == 0);
            run_txn(8'($urandom), 1'($urandom), 24'($urandom), 3'($urandom), 3'($urandom),
                    1'($urandom), $urandom, 2'($urandom_range(0, 2)), 2'($urandom_range(0, 2)),
                    2'($urandom_range(0, 2)), ($urandom_range(0, 1) == 1));
        end
        spurious = 1'b0;
        req = 1'b0;
        repeat (5) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
